// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter sharing one RAM port.
// The instruction-cache refill port owns the RAM for a whole burst.
// The load/store port owns it for a single beat.
// Ties are broken against whichever side was granted last.
// A per-grant watchdog forces an Ack when the RAM stalls too long,
// then raises a sticky bus-error flag.
module mem_port_arbiter #(
  parameter int dataW      = 32,
  parameter int AckTimeout = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             InsReq,
  input  logic [dataW-1:0] InsAddr,
  input  logic             InsLast,
  output logic             InsAck,
  output logic [dataW-1:0] InsRData,
  input  logic             DataReq,
  input  logic             DataWE,
  input  logic [dataW-1:0] DataAddr,
  input  logic [dataW-1:0] DataWData,
  output logic             DataAck,
  output logic [dataW-1:0] DataRData,
  output logic             MemReq,
  output logic             MemWE,
  output logic [dataW-1:0] MemAddr,
  output logic [dataW-1:0] MemWData,
  input  logic             MemAck,
  input  logic [dataW-1:0] MemRData,
  output logic             GrantIns,
  output logic             GrantData,
  output logic             BusErr
);

  localparam int CntW = $clog2(AckTimeout + 1);
  localparam logic [CntW-1:0]  CntLimit = CntW'(AckTimeout - 1);
  // RISC-V NOP (addi x0,x0,0) handed to the fetch side on a timeout
  localparam logic [dataW-1:0] NopInstr = dataW'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INS  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_last_data;      // 1 = DATA side was granted most recently
  logic            w_next_last_data;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_next_cnt;
  logic            r_bus_err;
  logic            w_set_err;
  logic            w_timeout;

  // Next-state, watchdog and combinational port muxing for the current owner
  always_comb begin
    w_next_state     = r_state;
    w_next_last_data = r_last_data;
    w_next_cnt       = r_cnt;
    w_set_err        = 1'b0;
    w_timeout        = 1'b0;
    InsAck           = 1'b0;
    InsRData         = '0;
    DataAck          = 1'b0;
    DataRData        = '0;
    MemReq           = 1'b0;
    MemWE            = 1'b0;
    MemAddr          = '0;
    MemWData         = '0;
    GrantIns         = 1'b0;
    GrantData        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (InsReq && (!DataReq || r_last_data)) begin
          w_next_state     = ST_INS;
          w_next_last_data = 1'b0;
          w_next_cnt       = '0;
        end else if (DataReq) begin
          w_next_state     = ST_DATA;
          w_next_last_data = 1'b1;
          w_next_cnt       = '0;
        end else begin
          w_next_state     = ST_IDLE;
        end
      end
      ST_INS: begin
        GrantIns  = 1'b1;
        MemReq    = InsReq;
        MemAddr   = InsAddr;
        w_timeout = InsReq && !MemAck && (r_cnt == CntLimit);
        InsAck    = (InsReq && MemAck) || w_timeout;
        InsRData  = w_timeout ? NopInstr : MemRData;
        if (w_timeout) begin
          w_next_cnt   = '0;
          w_set_err    = 1'b1;
          w_next_state = ST_IDLE;
        end else if (InsReq && MemAck) begin
          w_next_cnt   = '0;
          w_next_state = InsLast ? ST_IDLE : ST_INS;
        end else if (InsReq) begin
          w_next_cnt   = r_cnt + CntW'(1);
        end else begin
          w_next_cnt   = r_cnt;
        end
      end
      ST_DATA: begin
        GrantData = 1'b1;
        MemReq    = DataReq;
        MemWE     = DataWE;
        MemAddr   = DataAddr;
        MemWData  = DataWData;
        w_timeout = DataReq && !MemAck && (r_cnt == CntLimit);
        DataAck   = (DataReq && MemAck) || w_timeout;
        DataRData = (w_timeout || DataWE) ? '0 : MemRData;
        if (w_timeout) begin
          w_next_cnt   = '0;
          w_set_err    = 1'b1;
          w_next_state = ST_IDLE;
        end else if (DataReq && MemAck) begin
          w_next_cnt   = '0;
          w_next_state = ST_IDLE;
        end else if (DataReq) begin
          w_next_cnt   = r_cnt + CntW'(1);
        end else begin
          w_next_cnt   = r_cnt;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // State, tie-break history, watchdog counter and sticky error registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_data <= 1'b1;
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_last_data <= w_next_last_data;
      r_cnt       <= w_next_cnt;
      r_bus_err   <= r_bus_err | w_set_err;
    end
  end

  assign BusErr = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level owner model.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int TO = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int OWN_NONE = 0;
  localparam int OWN_INS  = 1;
  localparam int OWN_DATA = 2;

  logic clock = 1'b0;
  logic reset;
  logic InsReq, InsLast, InsAck;
  logic [W-1:0] InsAddr, InsRData;
  logic DataReq, DataWE, DataAck;
  logic [W-1:0] DataAddr, DataWData, DataRData;
  logic MemReq, MemWE, MemAck;
  logic [W-1:0] MemAddr, MemWData, MemRData;
  logic GrantIns, GrantData, BusErr;

  mem_port_arbiter #(.dataW(W), .AckTimeout(TO)) dut (
    .clock(clock), .reset(reset),
    .InsReq(InsReq), .InsAddr(InsAddr), .InsLast(InsLast),
    .InsAck(InsAck), .InsRData(InsRData),
    .DataReq(DataReq), .DataWE(DataWE), .DataAddr(DataAddr),
    .DataWData(DataWData), .DataAck(DataAck), .DataRData(DataRData),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData),
    .GrantIns(GrantIns), .GrantData(GrantData), .BusErr(BusErr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: who owns the RAM, who wins the next tie, unacked stall count
  int   owner;
  bit   prefer_ins;
  int   stall;
  bit   berr;

  // requester-side bookkeeping
  bit   ins_busy;
  int   beats_left;
  bit   prev_iack, prev_dack, prev_to, prev_rst;

  logic        e_mreq, e_mwe, e_iack, e_dack, to;
  logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
  int          thr;

  initial begin
    reset = 1'b1; InsReq = 1'b0; InsAddr = '0; InsLast = 1'b0;
    DataReq = 1'b0; DataWE = 1'b0; DataAddr = '0; DataWData = '0;
    MemAck = 1'b0; MemRData = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("rst_memreq",  {31'b0, MemReq}, 32'd0);
    check_val("rst_grants",  {30'b0, GrantIns, GrantData}, 32'd0);
    check_val("rst_buserr",  {31'b0, BusErr}, 32'd0);
    check_val("rst_acks",    {30'b0, InsAck, DataAck}, 32'd0);
    check_val("rst_maddr",   MemAddr, 32'd0);

    owner = OWN_NONE; prefer_ins = 1'b1; stall = 0; berr = 1'b0;
    ins_busy = 1'b0; beats_left = 0;
    prev_iack = 1'b0; prev_dack = 1'b0; prev_to = 1'b0; prev_rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      // requesters react to what happened last cycle
      if (prev_rst) begin
        ins_busy = 1'b0; beats_left = 0; InsReq = 1'b0; DataReq = 1'b0;
      end else begin
        if (prev_iack) begin
          beats_left--;
          if (beats_left == 0 || prev_to) begin
            ins_busy = 1'b0; beats_left = 0; InsReq = 1'b0;
          end else begin
            InsReq = ($urandom_range(0, 2) != 0);
            if (InsReq) InsAddr = $urandom;
          end
        end else if (!ins_busy) begin
          if ($urandom_range(0, 3) == 0) begin
            ins_busy = 1'b1; beats_left = $urandom_range(1, 4);
            InsReq = 1'b1; InsAddr = $urandom;
          end
        end else if (!InsReq) begin
          if ($urandom_range(0, 2) == 0) begin
            InsReq = 1'b1; InsAddr = $urandom;
          end
        end
        if (prev_dack) begin
          DataReq = 1'b0;
        end else if (!DataReq && $urandom_range(0, 3) == 0) begin
          DataReq = 1'b1; DataWE = $urandom_range(0, 1);
          DataAddr = $urandom; DataWData = $urandom;
        end
      end
      InsLast = (beats_left == 1);
      case ((i / 64) % 3)
        0:       thr = 70;
        1:       thr = 25;
        default: thr = 0;
      endcase
      MemAck   = ($urandom_range(0, 99) < thr);
      MemRData = $urandom;
      reset    = ($urandom_range(0, 199) == 0);
      #1;

      // expected outputs from the current owner
      e_mreq = 1'b0; e_mwe = 1'b0; e_iack = 1'b0; e_dack = 1'b0; to = 1'b0;
      e_maddr = '0; e_mwdata = '0; e_irdata = '0; e_drdata = '0;
      if (owner == OWN_INS) begin
        e_mreq   = InsReq;
        e_maddr  = InsAddr;
        to       = InsReq && !MemAck && (stall == TO - 1);
        e_iack   = (InsReq && MemAck) || to;
        e_irdata = to ? NOP : MemRData;
      end else if (owner == OWN_DATA) begin
        e_mreq   = DataReq;
        e_mwe    = DataWE;
        e_maddr  = DataAddr;
        e_mwdata = DataWData;
        to       = DataReq && !MemAck && (stall == TO - 1);
        e_dack   = (DataReq && MemAck) || to;
        e_drdata = (to || DataWE) ? 32'd0 : MemRData;
      end
      check_val("MemReq",    {31'b0, MemReq},    {31'b0, e_mreq});
      check_val("MemWE",     {31'b0, MemWE},     {31'b0, e_mwe});
      check_val("MemAddr",   MemAddr,            e_maddr);
      check_val("MemWData",  MemWData,           e_mwdata);
      check_val("InsAck",    {31'b0, InsAck},    {31'b0, e_iack});
      check_val("InsRData",  InsRData,           e_irdata);
      check_val("DataAck",   {31'b0, DataAck},   {31'b0, e_dack});
      check_val("DataRData", DataRData,          e_drdata);
      check_val("GrantIns",  {31'b0, GrantIns},  {31'b0, (owner == OWN_INS)});
      check_val("GrantData", {31'b0, GrantData}, {31'b0, (owner == OWN_DATA)});
      check_val("BusErr",    {31'b0, BusErr},    {31'b0, berr});

      // advance the model to the state after the coming edge
      if (reset) begin
        owner = OWN_NONE; prefer_ins = 1'b1; stall = 0; berr = 1'b0;
      end else if (owner == OWN_NONE) begin
        if (InsReq && DataReq) owner = prefer_ins ? OWN_INS : OWN_DATA;
        else if (InsReq)       owner = OWN_INS;
        else if (DataReq)      owner = OWN_DATA;
        if (owner != OWN_NONE) begin
          prefer_ins = (owner == OWN_DATA);
          stall = 0;
        end
      end else begin
        if (to) begin
          owner = OWN_NONE; berr = 1'b1; stall = 0;
        end else if ((owner == OWN_INS && e_iack && InsLast) || (owner == OWN_DATA && e_dack)) begin
          owner = OWN_NONE; stall = 0;
        end else if (e_mreq && MemAck) begin
          stall = 0;
        end else if (e_mreq) begin
          stall++;
        end
      end
      prev_iack = e_iack;
      prev_dack = e_dack;
      prev_to   = to;
      prev_rst  = reset;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- dataW, 32, data/address width.
- AckTimeout, 16, max consecutive unacked MemReq cycles before bus error (>=2).

REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- InsReq  in  1  instruction-cache refill beat request.
- InsAddr  in  dataW  beat read address.
- InsLast  in  1  current beat is final beat of refill burst.
- InsAck  out  1  beat complete; InsRData valid this cycle.
- InsRData  out  dataW  beat read data.
- DataReq  in  1  load/store request (single beat).
- DataWE  in  1  1=store, 0=load.
- DataAddr  in  dataW  load/store address.
- DataWData  in  dataW  store data.
- DataAck  out  1  transaction complete; DataRData valid for loads.
- DataRData  out  dataW  load data.
- MemReq  out  1  RAM request.
- MemWE  out  1  RAM write enable.
- MemAddr  out  dataW  RAM address.
- MemWData  out  dataW  RAM write data.
- MemAck  in  1  RAM completes current request this cycle.
- MemRData  in  dataW  RAM read data.
- GrantIns / GrantData  out  1 each  current owner (one-hot or both 0).
- BusErr  out  1  sticky timeout flag.

Function
REQ-003 FSM states IDLE, INS, DATA; GrantIns=(state==INS), GrantData=(state==DATA).
REQ-004 IDLE: sample requests; the next state SHALL be INS or DATA, taking effect on the next edge; no Mem activity while in IDLE.
REQ-005 Only one requester active in IDLE: grant it. Both active: grant the requester NOT granted last (LastGrant register, updated on every grant).
REQ-006 INS: MemReq=InsReq, MemWE=0, MemAddr=InsAddr, MemWData=0; InsAck=MemAck&InsReq, InsRData=MemRData, both combinational.
REQ-007 INS SHALL be held across the whole burst, including cycles with InsReq=0; exit to IDLE on the edge after the beat where InsAck=1 and InsLast=1.
REQ-008 DATA: MemReq=DataReq, MemWE=DataWE, MemAddr=DataAddr, MemWData=DataWData; DataAck=MemAck&DataReq, DataRData=DataWE?0:MemRData; exit to IDLE on the edge after DataAck.
REQ-009 Non-granted requester's Ack SHALL be 0 and its RData 0; requesters hold Req/Addr/WData stable until Ack.
REQ-010 Minimum latency: request in IDLE at cycle N -> MemReq at N+1 -> earliest Ack at N+1 (if MemAck same cycle); back-to-back grants separated by one IDLE cycle.
REQ-011 Timeout counter ($clog2(AckTimeout+1) bits): cleared on entering INS/DATA and on each MemAck; increments each cycle MemReq=1 and MemAck=0.
REQ-012 Counter reaching AckTimeout-1 with MemAck=0: that cycle force requester Ack=1 with RData=NOP (0x00000013) for INS or 0 for DATA; next edge BusErr<=1, state<=IDLE, counter<=0.
REQ-013 Timeout in INS ends the burst regardless of InsLast.
REQ-014 MemAck while MemReq=0 SHALL be ignored (no Ack, no counter effect).

Reset
REQ-015 reset=1 at an edge SHALL set state=IDLE, LastGrant=DATA (instruction wins first tie), counter=0, BusErr=0; all outputs 0 in the following cycle.
REQ-016 reset mid-burst or mid-transaction SHALL abandon it; no Ack is issued for the abandoned request.

Verification
REQ-017 Reset, then InsReq=1 and DataReq=1 in the same cycle -> GrantIns=1 next cycle; after the InsLast ack, IDLE for one cycle, then GrantData=1.
REQ-018 Store DataAddr=0x40, DataWData=0xDEADBEEF, MemAck 2 cycles after MemReq -> MemWE=1, MemAddr=0x40 throughout; DataAck=1 with DataRData=0; IDLE next cycle.
REQ-019 4-beat INS burst with a 3-cycle InsReq gap after beat 2 and DataReq held high -> GrantIns held throughout, DataAck=0 until burst ends; DATA granted after the one-cycle IDLE.
REQ-020 DATA load, MemAck never asserted -> DataAck=1 with DataRData=0 on the 16th MemReq cycle; BusErr=1 next cycle and stays 1 until reset.
REQ-021 Reset asserted in the middle of beat 3 of an INS burst -> MemReq=0 next cycle, no InsAck, state IDLE, LastGrant=DATA.
